lsu: RTL and testbench

Load/store unit sitting directly upstream of `dmem` in the barbecue datapath. It accepts one load or store request at a time from the execute stage, decodes the RISC-V access width from `funct3`, and drives the word address, unshifted write data and unshifted byte mask that `dmem` expects. For loads it extracts and sign- or zero-extends the addressed byte, halfword or word from the returned word. Misaligned and illegal-width accesses are flagged without touching memory.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_align.sv | 57 +++++
 rtl/lsu.sv | 110 +++++++++++
 tb/tb_lsu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: data width, RISC-V funct3 width
// codes and the FSM state type.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Width decode, load extraction/extension and byte-mask generation for the LSU.
// The misaligned flag is only produced when BBQ_LSU_MISALIGN_CHECK_EN is defined.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] wmask,
  output logic            misaligned,
  output logic            illegal
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted    = mem_rdata >> {addr, 3'b000};
    load_data  = '0;
    wmask      = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
        wmask     = {{(XLEN-8){1'b0}}, 8'hFF};
      end
      F3_BU: begin
        load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
        wmask     = {{(XLEN-8){1'b0}}, 8'hFF};
      end
      F3_H: begin
        load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        wmask     = {{(XLEN-16){1'b0}}, 16'hFFFF};
`ifdef BBQ_LSU_MISALIGN_CHECK_EN
        misaligned = addr[0];
`endif
      end
      F3_HU: begin
        load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
        wmask     = {{(XLEN-16){1'b0}}, 16'hFFFF};
`ifdef BBQ_LSU_MISALIGN_CHECK_EN
        misaligned = addr[0];
`endif
      end
      F3_W: begin
        load_data = shifted;
        wmask     = '1;
`ifdef BBQ_LSU_MISALIGN_CHECK_EN
        misaligned = |addr;
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit in front of dmem: IDLE -> ACCESS -> RESP.
// Alignment checking is enabled by defining BBQ_LSU_MISALIGN_CHECK_EN.
module lsu
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_wmask,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state, state_nx;
  logic            lat_we;
  logic [2:0]      lat_f3;
  logic [XLEN-1:0] lat_addr, lat_wdata;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            in_idle, accept, check_fail;
  logic [2:0]      al_f3;
  logic [1:0]      al_addr;
  logic [XLEN-1:0] al_load, al_wmask;
  logic            al_mis, al_ill;

  // One decoder serves both the accept-time check (live request) and the
  // ACCESS-cycle extraction (latched request).
  assign in_idle = (state == ST_IDLE);
  assign al_f3   = in_idle ? req_funct3    : lat_f3;
  assign al_addr = in_idle ? req_addr[1:0] : lat_addr[1:0];
  assign accept  = in_idle & req_valid;
  // Stores have no unsigned width codes.
  assign check_fail = al_ill | al_mis | (req_we & req_funct3[2]);

  lsu_align u_align (
    .funct3    (al_f3),
    .addr      (al_addr),
    .mem_rdata (mem_rdata),
    .load_data (al_load),
    .wmask     (al_wmask),
    .misaligned(al_mis),
    .illegal   (al_ill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nx = check_fail ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   if (resp_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        rdata_q   <= '0;
        err_q     <= check_fail;
      end
      if (state == ST_ACCESS && !lat_we) rdata_q <= al_load;
    end
  end

  always_comb begin
    req_ready  = in_idle & ~rst;
    resp_valid = (state == ST_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    mem_we     = 1'b0;
    if (state == ST_ACCESS) begin
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      mem_wmask = al_wmask;
      mem_we    = lat_we;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu with a byte-level reference memory
// and a behavioural dmem model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_wmask, mem_rdata;
  logic        mem_we;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // dmem environment: 64 words covering byte addresses 0x100..0x1FF
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we)
      mem[mem_addr[7:2]] <= (mem[mem_addr[7:2]] & ~(mem_wmask << {mem_addr[1:0], 3'b000}))
                          | ((mem_wdata & mem_wmask) << {mem_addr[1:0], 3'b000});
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] w, v;
    w = ref_mem[addr[7:2]] >> (8 * addr[1:0]);
    case (f3)
      3'd0: begin v = w % 256;   if (v >= 128)   v = v | 32'hFFFF_FF00; end
      3'd1: begin v = w % 65536; if (v >= 32768) v = v | 32'hFFFF_0000; end
      3'd4: v = w % 256;
      3'd5: v = w % 65536;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata, input int unsigned size);
    logic [31:0] w;
    int unsigned pos;
    w = ref_mem[addr[7:2]];
    for (int unsigned k = 0; k < size; k++) begin
      pos = addr[1:0] + k;
      if (pos < 4) w[8*pos +: 8] = wdata[8*k +: 8];
    end
    ref_mem[addr[7:2]] = w;
  endtask

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int unsigned hold);
    logic        exp_err;
    logic [31:0] exp_rd, exp_mask;
    int unsigned size, n;
    size     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    exp_mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    exp_err  = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef BBQ_LSU_MISALIGN_CHECK_EN
    if (!exp_err && (addr % size) != 0) exp_err = 1'b1;
`endif
    exp_rd = (we || exp_err) ? 32'd0 : model_load(f3, addr);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 16) begin @(negedge clk); n++; end
    check("req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    check("busy_ready", {31'd0, req_ready}, 32'd0);
    if (!exp_err) begin
      check("acc_valid", {31'd0, resp_valid}, 32'd0);
      check("acc_we",    {31'd0, mem_we}, {31'd0, we});
      check("acc_addr",  mem_addr, addr);
      check("acc_mask",  mem_wmask, exp_mask);
      if (we) check("acc_wdata", mem_wdata, wdata);
      @(posedge clk); #1;
    end else begin
      check("err_no_we", {31'd0, mem_we}, 32'd0);
    end
    if (we && !exp_err) model_store(addr, wdata, size);

    for (int unsigned i = 0; i <= hold; i++) begin
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_rdata", resp_rdata, exp_rd);
      check("resp_err",   {31'd0, resp_err}, {31'd0, exp_err});
      check("resp_ready_lo", {31'd0, req_ready}, 32'd0);
      check("resp_mem_we", {31'd0, mem_we}, 32'd0);
      if (i < hold) begin
        req_valid = 1'b1;
        @(posedge clk); #1;
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("idle_valid", {31'd0, resp_valid}, 32'd0);
    check("idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      mem[i]     = ref_mem[i];
    end
    ref_mem[0] = 32'h8899_AABB;
    mem[0]     = 32'h8899_AABB;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err",   {31'd0, resp_err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_mask", mem_wmask, 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    do_op(1'b0, 3'd0, 32'h101, 32'd0, 0);           // LB   -> FFFFFFAA
    do_op(1'b0, 3'd5, 32'h102, 32'd0, 0);           // LHU  -> 00008899
    do_op(1'b0, 3'd1, 32'h102, 32'd0, 0);           // LH   -> FFFF8899
    do_op(1'b1, 3'd0, 32'h103, 32'h1234_5677, 0);   // SB
    do_op(1'b0, 3'd2, 32'h100, 32'd0, 0);           // LW   -> 7799AABB
    check("sb_word", ref_mem[0], 32'h7799_AABB);
    do_op(1'b0, 3'd2, 32'h102, 32'd0, 0);           // misaligned LW
    do_op(1'b0, 3'd2, 32'h100, 32'd0, 3);           // backpressure
    do_op(1'b0, 3'd3, 32'h100, 32'd0, 1);           // illegal load code
    do_op(1'b1, 3'd4, 32'h104, 32'hDEAD_BEEF, 0);   // illegal store code

    // reset during ACCESS of SW 0x104
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h104; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("sw_acc_we", {31'd0, mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_drop_we", {31'd0, mem_we}, 32'd0);
    check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
    check("rst_busy_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rel_ready", {31'd0, req_ready}, 32'd1);
    check("rel_valid", {31'd0, resp_valid}, 32'd0);
    do_op(1'b0, 3'd2, 32'h104, 32'd0, 0);           // store must not have landed

    for (int unsigned t = 0; t < 150; t++)
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'h100 + $urandom_range(0, 255), $urandom, $urandom_range(0, 2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
